traffic_safety_monitor: RTL

//  Downstream checker on the four-way intersection controller. Samples the N/S/E/W car and pedestrian

---
 rtl/traffic_pkg.sv | 34 +++
 rtl/traffic_car_seq_chk.sv | 23 ++
 rtl/traffic_safety_monitor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared lamp codes, monitor state encodings and fault-class bit positions
// for the four-way intersection controller and its safety monitor.
package traffic_pkg;

   localparam logic [1:0] CAR_RED  = 2'b00;
   localparam logic [1:0] CAR_GRN  = 2'b01;
   localparam logic [1:0] CAR_YEL  = 2'b10;
   localparam logic [1:0] CAR_LEFT = 2'b11;

   localparam logic [1:0] PED_STOP = 2'b00;
   localparam logic [1:0] PED_WALK = 2'b01;

   typedef enum logic [1:0] {
      MON_IDLE  = 2'b00,
      MON_ARM   = 2'b01,
      MON_RUN   = 2'b10,
      MON_FAULT = 2'b11
   } mon_state_t;

   localparam int F_AXIS   = 0;
   localparam int F_PED    = 1;
   localparam int F_PAIR   = 2;
   localparam int F_TRANS  = 3;
   localparam int F_CYC    = 4;
   localparam int NUM_FAULT = 5;

   typedef struct packed {
      logic [1:0] n;
      logic [1:0] s;
      logic [1:0] e;
      logic [1:0] w;
   } lamp_set_t;

endpackage

// File: rtl/traffic_car_seq_chk.sv
// Flags an illegal car-lamp step between consecutive samples of one direction.
// Purely combinational; no state, no backpressure.
module traffic_car_seq_chk
   import traffic_pkg::*;
(
   input  logic [1:0] prev_code,
   input  logic [1:0] cur_code,
   output logic       illegal
);

   logic legal;

   always_comb begin
      legal = (prev_code == cur_code)
           || (prev_code == CAR_RED  && cur_code == CAR_GRN)
           || (prev_code == CAR_GRN  && cur_code == CAR_YEL)
           || (prev_code == CAR_YEL  && cur_code == CAR_LEFT)
           || (prev_code == CAR_LEFT && cur_code == CAR_YEL)
           || (prev_code == CAR_YEL  && cur_code == CAR_RED);
      illegal = !legal;
   end

endmodule

// File: rtl/traffic_safety_monitor.sv
// Checks intersection lamp/cycle samples, latching a sticky first-fault code and saturating count.
// Fault outputs update one clock after the offending sample; observe-only, no backpressure.
module traffic_safety_monitor
   import traffic_pkg::*;
#(
   parameter int CYCLE_MAX = 68,
   parameter int CYC_W     = 7,
   parameter int ERR_W     = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [1:0]       i_n_car,
   input  logic [1:0]       i_s_car,
   input  logic [1:0]       i_e_car,
   input  logic [1:0]       i_w_car,
   input  logic [1:0]       i_n_ped,
   input  logic [1:0]       i_s_ped,
   input  logic [1:0]       i_e_ped,
   input  logic [1:0]       i_w_ped,
   input  logic [CYC_W-1:0] i_cycle,
   output logic             o_fault,
   output logic [4:0]       o_fault_code,
   output logic [ERR_W-1:0] o_err_cnt,
   output logic             o_force_red,
   output logic [1:0]       o_state
);

   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLE_MAX);
   localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

   mon_state_t          state, state_nxt;
   lamp_set_t           cur_car, prev_car;
   logic [CYC_W-1:0]    prev_cyc;
   logic [CYC_W:0]      prev_inc;
   logic [3:0]          trans_bad;
   logic                check_en;
   logic                cyc_bad;
   logic [NUM_FAULT-1:0] raw_viol, viol;
   logic                any_viol;
   logic                fault;
   logic [4:0]          fault_code;
   logic [ERR_W-1:0]    err_cnt;

   assign cur_car = '{n: i_n_car, s: i_s_car, e: i_e_car, w: i_w_car};

   traffic_car_seq_chk u_seq_n (.prev_code(prev_car.n), .cur_code(cur_car.n), .illegal(trans_bad[0]));
   traffic_car_seq_chk u_seq_s (.prev_code(prev_car.s), .cur_code(cur_car.s), .illegal(trans_bad[1]));
   traffic_car_seq_chk u_seq_e (.prev_code(prev_car.e), .cur_code(cur_car.e), .illegal(trans_bad[2]));
   traffic_car_seq_chk u_seq_w (.prev_code(prev_car.w), .cur_code(cur_car.w), .illegal(trans_bad[3]));

   // Counter wrap CYCLE_MAX -> 1 is the only legal non-increment step.
   assign prev_inc = {1'b0, prev_cyc} + (CYC_W+1)'(1);
   assign cyc_bad  = (i_cycle == '0) || (i_cycle > CYC_LAST)
                  || !(({1'b0, i_cycle} == prev_inc) || (prev_cyc == CYC_LAST && i_cycle == CYC_ONE));

   always_comb begin
      raw_viol          = '0;
      raw_viol[F_AXIS]  = (i_n_car != CAR_RED || i_s_car != CAR_RED)
                       && (i_e_car != CAR_RED || i_w_car != CAR_RED);
      raw_viol[F_PED]   = (i_n_ped != PED_STOP && i_n_car != CAR_RED)
                       || (i_s_ped != PED_STOP && i_s_car != CAR_RED)
                       || (i_e_ped != PED_STOP && i_e_car != CAR_RED)
                       || (i_w_ped != PED_STOP && i_w_car != CAR_RED);
      raw_viol[F_PAIR]  = (i_n_car != i_s_car) || (i_e_car != i_w_car)
                       || (i_n_ped != i_s_ped) || (i_e_ped != i_w_ped);
      raw_viol[F_TRANS] = |trans_bad;
      raw_viol[F_CYC]   = cyc_bad;
   end

   assign check_en = (state == MON_RUN && i_en) || (state == MON_FAULT);
   assign viol     = check_en ? raw_viol : '0;
   assign any_viol = |viol;

   always_comb begin
      state_nxt = state;
      unique case (state)
         MON_IDLE:  if (i_en) state_nxt = MON_ARM;
         MON_ARM:   state_nxt = MON_RUN;
         MON_RUN: begin
            if (any_viol)   state_nxt = MON_FAULT;
            else if (!i_en) state_nxt = MON_IDLE;
         end
         MON_FAULT: state_nxt = MON_FAULT;
         default:   state_nxt = MON_IDLE;
      endcase
      if (i_clr) state_nxt = MON_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= MON_IDLE;
         prev_car <= '0;
         prev_cyc <= '0;
      end else begin
         state <= state_nxt;
         if (state != MON_IDLE) begin
            prev_car <= cur_car;
            prev_cyc <= i_cycle;
         end
      end
   end

   // Clear wins over a same-cycle violation; only the first violating sample sets the code.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault      <= 1'b0;
         fault_code <= '0;
         err_cnt    <= '0;
      end else if (i_clr) begin
         fault      <= 1'b0;
         fault_code <= '0;
         err_cnt    <= '0;
      end else if (any_viol) begin
         fault <= 1'b1;
         if (!fault) fault_code <= viol;
         if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
      end
   end

   assign o_fault      = fault;
   assign o_force_red  = fault;
   assign o_fault_code = fault_code;
   assign o_err_cnt    = err_cnt;
   assign o_state      = state;

endmodule
